// File: rtl/fd_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fd_fetch_pkg
//  Description : Constants and types shared by the fetch stage, the D/X stage
//                and the hazard unit of the five-stage processor.
//  Revision    : 1.0  initial release
// ============================================================================
package fd_fetch_pkg;

  localparam int          PC_W        = 32;
  localparam int          IMEM_AW_DEF = 12;
  localparam logic [31:0] NOP_INSTR   = 32'h0;

  // Fetch state is encoded by {resp_valid, skid_valid}.
  typedef enum logic [1:0] {
    ST_FILL = 2'b00,  // nothing returning from the ROM
    ST_HELD = 2'b01,  // skid holds the next instruction
    ST_RUN  = 2'b10,  // ROM response returning this cycle
    ST_BAD  = 2'b11   // unreachable
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } fd_entry_t;

  // Word-addressed PC: +1 with natural 32-bit wrap.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fd_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fd_fetch_if
//  Description : Bundle between the fetch stage and its surroundings: the
//                instruction ROM bus, hazard/redirect controls and the F/D
//                latch outputs.
//  Revision    : 1.0  initial release
//
//  Signals:
//    imem_addr       fetch -> ROM     ROM word address
//    imem_q          ROM   -> fetch   word at previous cycle's address
//    stall           hazard -> fetch  hold F/D and PC
//    redirect        X     -> fetch   taken branch/jump resolved in X
//    redirect_pc     X     -> fetch   redirect target
//    PC_FD           fetch -> D/X     PC of instruction in F/D
//    Instruction_FD  fetch -> D/X     instruction in F/D (nop when invalid)
//    valid_FD        fetch -> D/X     F/D holds a real instruction
// ============================================================================
interface fd_fetch_if
  import fd_fetch_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_DEF
) ();

  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_q;
  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    PC_FD;
  logic [31:0]        Instruction_FD;
  logic               valid_FD;

  // Fetch stage side
  modport master (
    output imem_addr, PC_FD, Instruction_FD, valid_FD,
    input  imem_q, stall, redirect, redirect_pc
  );

  // ROM / hazard unit / downstream side
  modport slave (
    input  imem_addr, PC_FD, Instruction_FD, valid_FD,
    output imem_q, stall, redirect, redirect_pc
  );

endinterface
`default_nettype wire

// File: rtl/fd_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fd_skid_buffer
//  Description : One-entry {instr, pc, valid} holding register that catches
//                the ROM response arriving while the pipeline is stalled.
//  Revision    : 1.0  initial release
//
//  Ports:
//    clk       in   clock
//    reset     in   asynchronous active-low reset
//    load_i    in   capture entry_i and mark valid
//    clear_i   in   invalidate entry (wins over load_i)
//    entry_i   in   {instr, pc} to capture
//    entry_o   out  held {instr, pc}
//    valid_o   out  entry is valid
// ============================================================================
module fd_skid_buffer
  import fd_fetch_pkg::*;
(
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic load_i,
  input  wire logic clear_i,
  input  wire fd_entry_t entry_i,
  output fd_entry_t entry_o,
  output logic      valid_o
);

  fd_entry_t entry_q, entry_d;
  logic      valid_q, valid_d;

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      entry_d = entry_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  assign entry_o = entry_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/fd_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : fd_fetch
//  Description : Fetch stage and F/D pipeline latch. Holds the PC, drives the
//                synchronous instruction ROM (data one cycle after address),
//                absorbs stalls with a one-entry skid buffer and bubbles on
//                redirects. Priority per edge: redirect > stall > normal.
//  Revision    : 1.0  initial release
//
//  Ports:
//    clk    in   clock, all state updates on rising edge
//    reset  in   asynchronous active-low reset, synchronous release
//    bus    --   fd_fetch_if.master: ROM bus, stall/redirect, F/D outputs
// ============================================================================
module fd_fetch
  import fd_fetch_pkg::*;
#(
  parameter int              IMEM_AW  = IMEM_AW_DEF,
  parameter logic [PC_W-1:0] RESET_PC = 32'd0
) (
  input  wire logic   clk,
  input  wire logic   reset,
  fd_fetch_if.master  bus
);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            resp_valid_q, resp_valid_d;
  logic [PC_W-1:0] resp_pc_q, resp_pc_d;
  fd_entry_t       fd_q, fd_d;
  logic            valid_fd_q, valid_fd_d;

  fd_entry_t       resp_entry;
  fd_entry_t       skid_entry;
  logic            skid_valid;
  logic            skid_load;
  logic            skid_clear;
  fetch_state_e    state;

  assign state         = fetch_state_e'({resp_valid_q, skid_valid});
  assign resp_entry    = '{instr: bus.imem_q, pc: resp_pc_q};
  assign bus.imem_addr = fetch_pc_q[IMEM_AW-1:0];

  fd_skid_buffer u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .entry_i (resp_entry),
    .entry_o (skid_entry),
    .valid_o (skid_valid)
  );

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_valid_d = 1'b0;
    resp_pc_d    = resp_pc_q;
    fd_d         = fd_q;
    valid_fd_d   = valid_fd_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;

    if (bus.redirect) begin
      // Everything in flight is on the wrong path.
      fetch_pc_d = bus.redirect_pc;
      skid_clear = 1'b1;
      fd_d.instr = NOP_INSTR;
      fd_d.pc    = '0;
      valid_fd_d = 1'b0;
    end else if (bus.stall) begin
      // The PC is held so the ROM re-reads the same address; that re-read is
      // dropped (resp_valid_d stays 0). A response already returning is
      // parked in the skid so it is not lost.
      skid_load = (state == ST_RUN);
    end else begin
      skid_clear   = 1'b1;
      fetch_pc_d   = pc_next(fetch_pc_q);
      resp_pc_d    = fetch_pc_q;
      resp_valid_d = 1'b1;
      case (state)
        ST_HELD: begin
          fd_d       = skid_entry;
          valid_fd_d = 1'b1;
        end
        ST_RUN: begin
          fd_d       = resp_entry;
          valid_fd_d = 1'b1;
        end
        default: begin
          fd_d.instr = NOP_INSTR;
          fd_d.pc    = '0;
          valid_fd_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      fd_q         <= '0;
      valid_fd_q   <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      fd_q         <= fd_d;
      valid_fd_q   <= valid_fd_d;
    end
  end

  assign bus.PC_FD          = fd_q.pc;
  assign bus.Instruction_FD = fd_q.instr;
  assign bus.valid_FD       = valid_fd_q;

  // A returning response and a full skid at once would mean one of them is
  // about to be lost.
  a_no_resp_with_skid: assert property (
    @(posedge clk) disable iff (!reset) state != ST_BAD
  );

endmodule
`default_nettype wire

// File: tb/tb_fd_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fd_fetch
//  Description : Directed bench for fd_fetch. ROM word at address a is
//                32'hA000_0000 + a. Expected F/D contents are hand-derived
//                per step.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fd_fetch;
  import fd_fetch_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  fd_fetch_if #(.IMEM_AW(12)) bus ();

  fd_fetch #(
    .IMEM_AW  (12),
    .RESET_PC (32'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data is the word at last cycle's address.
  always @(posedge clk) bus.imem_q <= 32'hA000_0000 + {20'd0, bus.imem_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // v=0 means a bubble: PC 0, nop, not valid.
  task automatic chk_fd(input string tag, input logic v, input logic [31:0] pc);
    logic [31:0] ei;
    ei = v ? (32'hA000_0000 + {20'd0, pc[11:0]}) : NOP_INSTR;
    chk({tag, ".valid"}, {31'd0, bus.valid_FD}, {31'd0, v});
    chk({tag, ".pc"},    bus.PC_FD, v ? pc : 32'd0);
    chk({tag, ".instr"}, bus.Instruction_FD, ei);
  endtask

  task automatic chk_addr(input string tag, input logic [31:0] exp);
    chk(tag, {20'd0, bus.imem_addr}, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    #1 reset = 1'b0;
    #2;
    chk_fd("reset", 1'b0, 32'd0);
    chk_addr("reset.addr", 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Free run: bubble after first edge, PC 0 after second, then 1/cycle.
    tick(); chk_fd("fill_e1", 1'b0, 32'd0);
    for (int k = 0; k <= 5; k++) begin
      tick(); chk_fd($sformatf("run_pc%0d", k), 1'b1, k);
    end
    chk_addr("run.addr", 32'd7);

    // Single-cycle stall while F/D holds PC 5.
    bus.stall = 1'b1;
    tick(); chk_fd("stall1_hold", 1'b1, 32'd5);
    chk_addr("stall1.addr", 32'd7);
    bus.stall = 1'b0;
    tick(); chk_fd("stall1_pc6", 1'b1, 32'd6);
    tick(); chk_fd("stall1_pc7", 1'b1, 32'd7);
    tick(); chk_fd("stall1_pc8", 1'b1, 32'd8);

    // Four-cycle stall, skid supplies PC 9 on release.
    bus.stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); chk_fd($sformatf("stall4_hold%0d", k), 1'b1, 32'd8);
    end
    bus.stall = 1'b0;
    tick(); chk_fd("stall4_pc9", 1'b1, 32'd9);
    tick(); chk_fd("stall4_pc10", 1'b1, 32'd10);

    // Redirect to 40 with F/D at PC 10: two bubbles then 40, 41.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'd40;
    tick(); chk_fd("redir_b1", 1'b0, 32'd0);
    chk_addr("redir.addr", 32'd40);
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    tick(); chk_fd("redir_b2", 1'b0, 32'd0);
    tick(); chk_fd("redir_pc40", 1'b1, 32'd40);
    tick(); chk_fd("redir_pc41", 1'b1, 32'd41);

    // Enter HELD (skid = PC 42), then redirect+stall: skid discarded.
    bus.stall = 1'b1;
    tick(); chk_fd("held_hold41", 1'b1, 32'd41);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'd40;
    tick(); chk_fd("rs_b1", 1'b0, 32'd0);
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.stall       = 1'b0;
    tick(); chk_fd("rs_b2", 1'b0, 32'd0);
    tick(); chk_fd("rs_pc40", 1'b1, 32'd40);
    tick(); chk_fd("rs_pc41", 1'b1, 32'd41);

    // Fill the skid, then reset mid-cycle: outputs clear without an edge.
    bus.stall = 1'b1;
    tick(); chk_fd("pre_rst_hold41", 1'b1, 32'd41);
    #3 reset = 1'b0;
    #1;
    chk_fd("mid_reset", 1'b0, 32'd0);
    chk_addr("mid_reset.addr", 32'd0);
    bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick(); chk_fd("rerun_fill", 1'b0, 32'd0);
    tick(); chk_fd("rerun_pc0", 1'b1, 32'd0);
    tick(); chk_fd("rerun_pc1", 1'b1, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fd_fetch.md
# fd_fetch

Fetch stage and F/D pipeline latch of the five-stage processor. Holds the program counter and drives the synchronous instruction ROM, whose data returns one cycle after the address. It delivers each instruction with its PC to the D/X stage. It absorbs hazard-unit stalls without losing or duplicating instructions, using a one-entry skid buffer. It flushes on control-flow redirects resolved in X.

## Interface
Parameters:
- IMEM_AW, 12, instruction ROM address width; `imem_addr = fetch_pc[IMEM_AW-1:0]`.
- RESET_PC, 32'd0, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low: 0 clears all state immediately, release is synchronous to clk.
- imem_addr  out  IMEM_AW  ROM address, combinational from fetch_pc.
- imem_q  in  32  ROM data; word at the address presented in the previous cycle.
- stall  in  1  hazard unit: hold F/D contents and PC.
- redirect  in  1  taken branch/jump/bex resolved in X.
- redirect_pc  in  32  target PC when redirect=1.
- PC_FD  out  32  PC of instruction in F/D.
- Instruction_FD  out  32  instruction in F/D; 32'h0 (nop) when invalid.
- valid_FD  out  1  F/D holds a real instruction.

## Operation
State registers:
- fetch_pc: address being presented.
- resp_valid / resp_pc: imem_q this cycle is meaningful and belongs to resp_pc.
- skid_valid / skid_instr / skid_pc.
- The F/D registers.

FSM is encoded by (resp_valid, skid_valid):
- FILL (0,0): nothing returning.
- RUN (1,0): a response is returning this cycle.
- HELD (0,1): the skid holds the next instruction.
- (1,1) is illegal and must never occur; assert on it.

Priority per edge is redirect > stall > normal.
- **redirect=1 (any state):**
  - fetch_pc <= redirect_pc.
  - resp_valid <= 0 and skid_valid <= 0.
  - F/D <= bubble: PC_FD=0, Instruction_FD=0, valid_FD=0.
  - Next state is FILL.
- **stall=1, redirect=0:**
  - F/D and fetch_pc hold.
  - If RUN: skid <= {imem_q, resp_pc}, skid_valid <= 1, next state HELD.
  - Otherwise the skid holds.
  - resp_valid <= 0 in every case; the re-read of the held address is discarded.
- **stall=0, redirect=0:**
  - Source for F/D:
    - HELD: skid.
    - RUN: {imem_q, resp_pc}, valid=1.
    - FILL: bubble.
  - skid_valid <= 0.
  - fetch_pc <= fetch_pc + 1, with 32-bit wrap.
  - resp_pc <= fetch_pc and resp_valid <= 1; next state RUN.

PC arithmetic:
- Word-addressed; increment by 1.
- No alignment checks.
- Address bits above IMEM_AW are ignored by the ROM but kept in PC_FD.

## Timing
Reset values:
- fetch_pc=RESET_PC.
- resp_valid=0, skid_valid=0.
- PC_FD=0, Instruction_FD=0, valid_FD=0.
- imem_addr=RESET_PC[IMEM_AW-1:0].

Latency and throughput:
- An address presented in cycle t is visible on F/D outputs after the edge ending cycle t+1. Address-to-F/D latency is two edges.
- First valid instruction after reset release appears after the 2nd edge.
- Unstalled throughput is one instruction per cycle.

Stall:
- Any stall length, including back-to-back stalls, produces no duplicates and no drops.
- On release from HELD, the skid entry appears after one edge and the following PC after the next, with no bubble.

Redirect:
- Produces exactly two bubbles before redirect_pc reaches F/D.
- redirect together with stall: redirect wins; F/D is bubbled, not held.

Reset:
- Asserted mid-operation, it clears everything asynchronously.
- No ROM data is accepted on the first edge after release (FILL).

## Structure
- Shared processor package holds: NOP_INSTR = 32'h0, the PC width of 32, and the IMEM_AW default. The D/X stage and hazard unit use the same constants.
- One natural sub-module: fd_skid_buffer, a one-entry {instr, pc, valid} register with load/clear. Everything else (PC register, resp tracking, F/D latch) lives in fd_fetch.

## Test plan
- **Reset then free-run**, ROM[i]=32'hA000_0000+i, RESET_PC=0, stall=0: after 2nd edge PC_FD=0 / Instruction_FD=A000_0000; then one per cycle, PC 1,2,3,…
- **Single-cycle stall in RUN** at the edge where F/D holds PC 5: F/D shows PC 5 for 2 cycles, then 6, 7, 8 with no gap or repeat.
- **Stall held 4 cycles, then released:** F/D frozen 4 cycles; the skid supplies the next PC immediately on release; the sequence stays contiguous.
- **redirect=1, redirect_pc=40 with F/D at PC 10:** two cycles valid_FD=0 with Instruction_FD=0, then PC 40, 41.
- **redirect and stall asserted together while HELD:** skid discarded; F/D bubbled; PC 40 arrives after two edges; PC 11 never appears.
- **Reset asserted mid-stream with skid full:** all outputs 0 immediately, without waiting for an edge; after release PC_FD=RESET_PC after 2 edges.
